// File: rtl/da_channel_scheduler.sv
// Routes USB3 cache words into per-channel DA sample RAMs, BURST_LEN words per channel.
// Define DA_SCHED_CNT_EN to build the pkt_cnt/err_cnt statistics counters.
module da_channel_scheduler #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned AW        = 5
) (
  input  logic              rdclock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic [NUM_CH-1:0] wren_for_ram,
  output logic [AW-1:0]     ram_addr,
  output logic [31:0]       ram_data,
  output logic              busy,
  output logic              pkt_done,
  output logic              hdr_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cur_ch_q, cur_ch_d;
  logic [3:0]          rem_q, rem_d;
  logic [AW-1:0]       word_cnt_q, word_cnt_d;
  logic [NUM_CH-1:0]   wren_q, wren_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic [31:0]         ram_data_q, ram_data_d;
  logic                busy_q, busy_d;
  logic                pkt_done_q, pkt_done_d;
  logic                hdr_err_q, hdr_err_d;

  logic accept;
  logic is_hdr;

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;
  assign is_hdr   = ((in_data & 32'hFF0000FF) == 32'hFF0000FF) &&
                    (in_data[23:20] == 4'h0) && (in_data[11:8] == 4'h0);

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    rem_d      = rem_q;
    word_cnt_d = word_cnt_q;
    wren_d     = '0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    hdr_err_d  = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      cur_ch_d   = '0;
      rem_d      = '0;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_hdr) begin
              state_d    = S_XFER;
              cur_ch_d   = CW'(in_data[19:16]);
              rem_d      = in_data[15:12];
              word_cnt_d = '0;
            end else begin
              hdr_err_d = 1'b1;
            end
          end
        end
        S_XFER: begin
          if (accept) begin
            wren_d     = NUM_CH'(1) << cur_ch_q;
            ram_addr_d = word_cnt_q;
            ram_data_d = in_data;
            if (word_cnt_q == AW'(BURST_LEN - 1)) begin
              word_cnt_d = '0;
              cur_ch_d   = (cur_ch_q == CW'(NUM_CH - 1)) ? '0 : cur_ch_q + CW'(1);
              if (rem_q == 4'h0) state_d = S_DONE;
              else               rem_d   = rem_q - 4'h1;
            end else begin
              word_cnt_d = word_cnt_q + AW'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Status flops track the next state so they line up with state_q.
    busy_d     = (state_d == S_XFER);
    pkt_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge rdclock) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_ch_q   <= '0;
      rem_q      <= '0;
      word_cnt_q <= '0;
      wren_q     <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      rem_q      <= rem_d;
      word_cnt_q <= word_cnt_d;
      wren_q     <= wren_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign wren_for_ram = wren_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  assign busy         = busy_q;
  assign pkt_done     = pkt_done_q;
  assign hdr_err      = hdr_err_q;

`ifdef DA_SCHED_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q + {15'd0, pkt_done_d};
    err_cnt_d = err_cnt_q + {15'd0, hdr_err_d};
  end

  always_ff @(posedge rdclock) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule
